// File: rtl/box_outline_writer_pkg.sv
// Shared constants for the box outline writer: default geometry, field widths
// and FSM state encodings.
package box_outline_writer_pkg;

    localparam int DEF_X_SZ    = 3;
    localparam int DEF_Y_SZ    = 3;
    localparam int DEF_ADDR_SZ = 6;
    localparam int DEF_COL_SZ  = 3;
    localparam int DEF_WIDTH   = 6;
    localparam int DEF_HEIGHT  = 6;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_TOP    = 3'd1;
    localparam logic [2:0] S_RIGHT  = 3'd2;
    localparam logic [2:0] S_BOTTOM = 3'd3;
    localparam logic [2:0] S_LEFT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

endpackage

// File: rtl/box_outline_writer_addr.sv
// Frame address translator: addr = y*6 + x, built from shifts so no multiplier
// is needed for the 6-pixel row stride.
module address_translator #(
    parameter int X_SZ    = 3,
    parameter int Y_SZ    = 3,
    parameter int ADDR_SZ = 6
) (
    input  logic [X_SZ-1:0]    x,
    input  logic [Y_SZ-1:0]    y,
    output logic [ADDR_SZ-1:0] addr
);

    always_comb begin
        addr = (ADDR_SZ'(y) << 2) + (ADDR_SZ'(y) << 1) + ADDR_SZ'(x);
    end

endmodule

// File: rtl/box_outline_writer.sv
// Draws a one-pixel rectangle outline into the frame RAM, one write per clock,
// walking the perimeter clockwise: top, right, bottom, left.
module box_outline_writer
    import box_outline_writer_pkg::*;
#(
    parameter int X_SZ    = DEF_X_SZ,
    parameter int Y_SZ    = DEF_Y_SZ,
    parameter int ADDR_SZ = DEF_ADDR_SZ,
    parameter int COL_SZ  = DEF_COL_SZ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HEIGHT  = DEF_HEIGHT
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [X_SZ-1:0]    left,
    input  logic [X_SZ-1:0]    right,
    input  logic [Y_SZ-1:0]    top,
    input  logic [Y_SZ-1:0]    bottom,
    input  logic [COL_SZ-1:0]  colour,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               wr_en,
    output logic [ADDR_SZ-1:0] wr_addr,
    output logic [COL_SZ-1:0]  wr_data
);

    localparam logic [X_SZ-1:0] X_MAX = X_SZ'(WIDTH - 1);
    localparam logic [Y_SZ-1:0] Y_MAX = Y_SZ'(HEIGHT - 1);

    logic [2:0]         state;
    logic [X_SZ-1:0]    boxL, boxR, curX;
    logic [Y_SZ-1:0]    boxT, boxB, curY;
    logic               errPend;
    logic               boxOk;
    logic               beatState;
    logic [ADDR_SZ-1:0] beatAddr;

    assign boxOk = (left <= right) && (top <= bottom) &&
                   (right <= X_MAX) && (bottom <= Y_MAX);

    assign beatState = (state == S_TOP) || (state == S_RIGHT) ||
                       (state == S_BOTTOM) || (state == S_LEFT);

    address_translator #(
        .X_SZ    (X_SZ),
        .Y_SZ    (Y_SZ),
        .ADDR_SZ (ADDR_SZ)
    ) uAddr (
        .x    (curX),
        .y    (curY),
        .addr (beatAddr)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            boxL    <= '0;
            boxR    <= '0;
            boxT    <= '0;
            boxB    <= '0;
            curX    <= '0;
            curY    <= '0;
            errPend <= 1'b0;
        end else begin
            busy  <= beatState;
            wr_en <= beatState;
            done  <= 1'b0;
            err   <= 1'b0;
            if (beatState) begin
                wr_addr <= beatAddr;
            end

            // Each edge state emits the pixel at (curX,curY), then either steps
            // along the edge or hops to the first pixel of the next non-empty edge.
            case (state)
                S_IDLE, S_DONE: begin
                    if (state == S_DONE) begin
                        done <= 1'b1;
                        err  <= errPend;
                    end
                    state <= S_IDLE;
                    // DONE also accepts start so a new job can follow back-to-back.
                    if (start) begin
                        boxL    <= left;
                        boxR    <= right;
                        boxT    <= top;
                        boxB    <= bottom;
                        curX    <= left;
                        curY    <= top;
                        wr_data <= colour;
                        errPend <= !boxOk;
                        state   <= boxOk ? S_TOP : S_DONE;
                    end
                end
                S_TOP: begin
                    if (curX == boxR) begin
                        if (boxT == boxB) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_RIGHT;
                            curY  <= curY + 1'b1;
                        end
                    end else begin
                        curX <= curX + 1'b1;
                    end
                end
                S_RIGHT: begin
                    if (curY == boxB) begin
                        if (boxL == boxR) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_BOTTOM;
                            curX  <= curX - 1'b1;
                        end
                    end else begin
                        curY <= curY + 1'b1;
                    end
                end
                S_BOTTOM: begin
                    if (curX == boxL) begin
                        // Boxes two rows tall have no interior left column.
                        if ((boxB - boxT) < Y_SZ'(2)) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_LEFT;
                            curY  <= curY - 1'b1;
                        end
                    end else begin
                        curX <= curX - 1'b1;
                    end
                end
                S_LEFT: begin
                    if (curY == boxT + 1'b1) begin
                        state <= S_DONE;
                    end else begin
                        curY <= curY - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_box_outline_writer.sv
// Self-checking bench for box_outline_writer: table of boxes, randomized boxes
// against a perimeter-ordering model, plus busy-restart and mid-job reset cases.
module tb_box_outline_writer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [2:0] left, right, top, bottom, colour;
    logic       busy, done, err, wr_en;
    logic [5:0] wr_addr;
    logic [2:0] wr_data;

    int total = 0;
    int bad   = 0;

    int expQ[$];
    bit expErr;

    typedef struct {
        int l, r, t, b, c, n;
        bit e;
    } vec_t;

    vec_t tbl[9];

    box_outline_writer dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .left    (left),
        .right   (right),
        .top     (top),
        .bottom  (bottom),
        .colour  (colour),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Model: every boundary pixel gets its clockwise distance from (left,top);
    // the write order is simply ascending distance.
    task automatic buildExp(input int l, input int r, input int t, input int b);
        int slot[36];
        int w, h, key;
        expQ.delete();
        expErr = !(l <= r && t <= b && r < 6 && b < 6);
        if (expErr) return;
        w = r - l + 1;
        h = b - t + 1;
        for (int k = 0; k < 36; k++) slot[k] = -1;
        for (int y = t; y <= b; y++) begin
            for (int x = l; x <= r; x++) begin
                if (!(x == l || x == r || y == t || y == b)) continue;
                if (y == t)      key = x - l;
                else if (x == r) key = (w - 1) + (y - t);
                else if (y == b) key = (w - 1) + (h - 1) + (r - x);
                else             key = 2 * (w - 1) + (h - 1) + (b - y);
                slot[key] = y * 6 + x;
            end
        end
        for (int k = 0; k < 36; k++) if (slot[k] >= 0) expQ.push_back(slot[k]);
    endtask

    task automatic runJob(input int l, input int r, input int t, input int b,
                          input int c, input bit poke);
        int n;
        bit seen[64];
        bit dup;
        dup = 1'b0;
        for (int k = 0; k < 64; k++) seen[k] = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        left   = 3'(l);
        right  = 3'(r);
        top    = 3'(t);
        bottom = 3'(b);
        colour = 3'(c);
        @(posedge clk); #1;
        start  = 1'b0;
        colour = colour ^ 3'b111;
        chk("busy at start edge", busy, 0);
        n = expErr ? 0 : expQ.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (poke && i == 1) begin
                start = 1'b1; left = 3'd0; right = 3'd5; top = 3'd0; bottom = 3'd5;
            end
            if (poke && i == 2) start = 1'b0;
            chk("beat wr_en", wr_en, 1);
            chk("beat busy", busy, 1);
            chk("beat done", done, 0);
            chk($sformatf("beat %0d addr", i), wr_addr, expQ[i]);
            chk("beat data", wr_data, c & 7);
            if (seen[wr_addr]) dup = 1'b1;
            seen[wr_addr] = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("done pulse", done, 1);
        chk("err pulse", err, expErr);
        chk("done wr_en", wr_en, 0);
        chk("done busy", busy, 0);
        chk("duplicate addr", dup, 0);
        @(posedge clk); #1;
        chk("done one cycle", done, 0);
        chk("err one cycle", err, 0);
        chk("no extra beat", wr_en, 0);
    endtask

    task automatic doJob(input int l, input int r, input int t, input int b,
                         input int c, input bit poke);
        buildExp(l, r, t, b);
        runJob(l, r, t, b, c, poke);
    endtask

    task automatic chkIdleOutputs(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " err"}, err, 0);
        chk({tag, " wr_en"}, wr_en, 0);
        chk({tag, " wr_addr"}, wr_addr, 0);
        chk({tag, " wr_data"}, wr_data, 0);
    endtask

    initial begin
        tbl[0] = '{l:1, r:3, t:1, b:2, c:5, n:6,  e:0};
        tbl[1] = '{l:4, r:4, t:4, b:4, c:3, n:1,  e:0};
        tbl[2] = '{l:0, r:5, t:0, b:5, c:6, n:20, e:0};
        tbl[3] = '{l:0, r:3, t:2, b:2, c:4, n:4,  e:0};
        tbl[4] = '{l:1, r:2, t:1, b:2, c:2, n:4,  e:0};
        tbl[5] = '{l:0, r:2, t:0, b:4, c:1, n:12, e:0};
        tbl[6] = '{l:4, r:2, t:0, b:1, c:2, n:0,  e:1};
        tbl[7] = '{l:0, r:6, t:0, b:1, c:7, n:0,  e:1};
        tbl[8] = '{l:1, r:1, t:3, b:2, c:7, n:0,  e:1};

        resetn = 1'b0; start = 1'b0;
        left = '0; right = '0; top = '0; bottom = '0; colour = '0;
        repeat (2) @(posedge clk);
        #1;
        chkIdleOutputs("reset");
        resetn = 1'b1;

        foreach (tbl[i]) begin
            buildExp(tbl[i].l, tbl[i].r, tbl[i].t, tbl[i].b);
            chk($sformatf("vec %0d err class", i), expErr, tbl[i].e);
            chk($sformatf("vec %0d beat count", i), expQ.size(), tbl[i].n);
            runJob(tbl[i].l, tbl[i].r, tbl[i].t, tbl[i].b, tbl[i].c, 1'b0);
        end

        // Vertical line with a second start pulsed mid-job.
        doJob(2, 2, 0, 3, 3, 1'b1);

        // Full-frame job reset after beat 3; then case-1 from fixed addresses.
        buildExp(0, 5, 0, 5);
        @(negedge clk);
        start = 1'b1; left = 3'd0; right = 3'd5; top = 3'd0; bottom = 3'd5; colour = 3'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre-reset beat3 addr", wr_addr, 2);
        resetn = 1'b0;
        @(posedge clk); #1;
        chkIdleOutputs("mid-job reset");
        resetn = 1'b1;
        expErr = 1'b0;
        expQ = '{7, 8, 9, 15, 14, 13};
        runJob(1, 3, 1, 2, 5, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int a, b2, c2, d2;
            a  = $urandom_range(0, 6);
            b2 = $urandom_range(0, 6);
            c2 = $urandom_range(0, 6);
            d2 = $urandom_range(0, 6);
            if ($urandom_range(0, 3) != 0) begin
                if (a > b2)  begin int s = a;  a  = b2; b2 = s; end
                if (c2 > d2) begin int s = c2; c2 = d2; d2 = s; end
            end
            doJob(a, b2, c2, d2, $urandom_range(0, 7), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
